seteseg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//   One shared hex decoder sits downstream of nibble; this block feeds it.
//   Per slot: presents one digit's 4-bit value on nibble, drives that digit's anode enable.

---
 rtl/seteseg_pkg.sv | 18 +
 rtl/seteseg_scan_ctrl_if.sv | 31 +++
 rtl/seteseg_regfile.sv | 34 +++
 rtl/seteseg_scan_ctrl.sv | 109 ++++++++++
 tb/tb_seteseg_scan_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/seteseg_pkg.sv
// Shared types and helpers for the 7-segment scan controller slice.
package seteseg_pkg;

  typedef enum logic [1:0] {
    GUARD  = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Anode-off level for the common-anode display (enables are active-low).
  localparam logic SEG_OFF = 1'b1;

  // Index/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/seteseg_scan_ctrl_if.sv
// Write port plus display-side outputs of the scan controller.
interface seteseg_scan_ctrl_if
  import seteseg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIGIT_W  = clog2_min1(N_DIGITS)
) ();

  // Handshake: a write is accepted on any rising clk edge where wr_valid and
  // wr_ready are both high; wr_digit/wr_value must be stable while wr_valid is
  // high, and wr_ready does not depend combinationally on wr_valid.
  logic                wr_valid;
  logic [DIGIT_W-1:0]  wr_digit;
  logic [3:0]          wr_value;
  logic                wr_ready;
  logic [N_DIGITS-1:0] blank_mask;
  logic [3:0]          nibble;
  logic [N_DIGITS-1:0] digit_en;
  logic                frame_tick;

  modport master (
    output wr_valid, wr_digit, wr_value, blank_mask,
    input  wr_ready, nibble, digit_en, frame_tick
  );

  modport slave (
    input  wr_valid, wr_digit, wr_value, blank_mask,
    output wr_ready, nibble, digit_en, frame_tick
  );

endinterface

// File: rtl/seteseg_regfile.sv
// Shadow/active digit registers: writes land in shadow, commit copies to active.
module seteseg_regfile
  import seteseg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIGIT_W  = clog2_min1(N_DIGITS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DIGIT_W-1:0]       wr_digit,
  input  logic [3:0]               wr_value,
  input  logic                     commit,
  output logic [N_DIGITS-1:0][3:0] active
);

  logic [N_DIGITS-1:0][3:0] shadow;

  // Out-of-range indices match no slot, so those writes simply vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (wr_en) begin
        for (int i = 0; i < N_DIGITS; i++) begin
          if (wr_digit == DIGIT_W'(i)) shadow[i] <= wr_value;
        end
      end
      if (commit) active <= shadow;
    end
  end

endmodule

// File: rtl/seteseg_scan_ctrl.sv
// Time-multiplexed N-digit common-anode scan controller with per-frame commit.
module seteseg_scan_ctrl
  import seteseg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 8,
  parameter int DIGIT_W     = clog2_min1(N_DIGITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seteseg_scan_ctrl_if.slave   bus,
  output state_t               dbg_state
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CNT_W   = clog2_min1(CNT_MAX);
  localparam int IDX_W   = clog2_min1(N_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic [CNT_W-1:0]         cnt;
  logic [3:0]               nibble_q;
  logic [N_DIGITS-1:0]      digit_en_q;
  logic                     wr_ready_q;
  logic                     frame_tick_q;
  logic [N_DIGITS-1:0][3:0] active;

  seteseg_regfile #(
    .N_DIGITS (N_DIGITS),
    .DIGIT_W  (DIGIT_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bus.wr_valid & wr_ready_q),
    .wr_digit (bus.wr_digit),
    .wr_value (bus.wr_value),
    .commit   (state == COMMIT),
    .active   (active)
  );

  // wr_ready and frame_tick are registered so they are valid for exactly the
  // COMMIT cycle; the commit itself happens at the edge that leaves COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= GUARD;
      idx          <= '0;
      cnt          <= '0;
      nibble_q     <= '0;
      digit_en_q   <= {N_DIGITS{SEG_OFF}};
      wr_ready_q   <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      wr_ready_q   <= 1'b1;
      frame_tick_q <= 1'b0;
      case (state)
        GUARD: begin
          if (cnt == BLANK_LAST) begin
            cnt        <= '0;
            state      <= SCAN;
            nibble_q   <= active[idx];
            digit_en_q <= {N_DIGITS{SEG_OFF}};
            if (!bus.blank_mask[idx]) digit_en_q[idx] <= ~SEG_OFF;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt        <= '0;
            digit_en_q <= {N_DIGITS{SEG_OFF}};
            if (idx == IDX_LAST) begin
              state        <= COMMIT;
              wr_ready_q   <= 1'b0;
              frame_tick_q <= 1'b1;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= GUARD;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        COMMIT: begin
          idx   <= '0;
          cnt   <= '0;
          state <= GUARD;
        end
        default: begin
          idx        <= '0;
          cnt        <= '0;
          digit_en_q <= {N_DIGITS{SEG_OFF}};
          state      <= GUARD;
        end
      endcase
    end
  end

  assign bus.nibble     = nibble_q;
  assign bus.digit_en   = digit_en_q;
  assign bus.wr_ready   = wr_ready_q;
  assign bus.frame_tick = frame_tick_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_seteseg_scan_ctrl.sv
// Bench for seteseg_scan_ctrl: frame-position reference model plus directed and random writes.
module tb_seteseg_scan_ctrl;
  import seteseg_pkg::*;

  localparam int N     = 4;
  localparam int RDIV  = 4;
  localparam int BCYC  = 2;
  localparam int DW    = 3;
  localparam int SLOT  = RDIV + BCYC;
  localparam int FRAME = N * SLOT + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  state_t dbg_state;
  always #5 clk = ~clk;

  seteseg_scan_ctrl_if #(.N_DIGITS(N), .DIGIT_W(DW)) bus ();

  seteseg_scan_ctrl #(
    .N_DIGITS    (N),
    .REFRESH_DIV (RDIV),
    .BLANK_CYC   (BCYC),
    .DIGIT_W     (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n !== 1'b0)
      assert ($countones(~bus.digit_en) <= 1)
        else $error("FAIL onehot_assert: digit_en=%b", bus.digit_en);
  end

  // ---------------- reference model ----------------
  // Position within the 25-cycle frame; slot s occupies [s*6, s*6+5], with the
  // first BCYC cycles dark, and the last cycle of the frame is the commit.
  int         m_pos;
  logic [3:0] m_shadow[N];
  logic [3:0] m_active[N];
  logic [3:0] m_nib;
  logic       m_dark;
  logic [3:0] exp_q[$];

  task automatic model_reset();
    m_pos  = 0;
    m_nib  = 4'h0;
    m_dark = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = 4'h0;
      m_active[i] = 4'h0;
    end
  endtask

  function automatic logic [N-1:0] exp_en(input int p, input logic dark);
    int s;
    int q;
    s = p / SLOT;
    q = p % SLOT;
    if (p == FRAME - 1 || q < BCYC || dark) return {N{1'b1}};
    return ~(N'(1) << s);
  endfunction

  // Compare this cycle, advance the model across the next edge, move on.
  task automatic step();
    logic is_commit;
    int   np;
    is_commit = (m_pos == FRAME - 1);
    check("digit_en",   32'(bus.digit_en),   32'(exp_en(m_pos, m_dark)));
    check("nibble",     32'(bus.nibble),     32'(m_nib));
    check("frame_tick", 32'(bus.frame_tick), 32'(is_commit));
    check("wr_ready",   32'(bus.wr_ready),   32'(!is_commit));
    check("onehot",     32'($countones(~bus.digit_en) <= 1), 32'(1));
    if (is_commit) begin
      for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
    end
    if (bus.wr_valid && !is_commit && int'(bus.wr_digit) < N)
      m_shadow[bus.wr_digit] = bus.wr_value;
    np = (m_pos + 1) % FRAME;
    if (np != FRAME - 1 && (np % SLOT) == BCYC) begin
      m_nib  = m_active[np / SLOT];
      m_dark = bus.blank_mask[np / SLOT];
    end
    m_pos = np;
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  task automatic set_wr(input logic v, input logic [DW-1:0] d, input logic [3:0] val);
    bus.wr_valid = v;
    bus.wr_digit = d;
    bus.wr_value = val;
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < FRAME && m_pos != target; k++) step();
    check("run_to_reached", 32'(m_pos), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digit_en"},   32'(bus.digit_en),   32'({N{1'b1}}));
    check({tag, "_nibble"},     32'(bus.nibble),     32'(0));
    check({tag, "_frame_tick"}, 32'(bus.frame_tick), 32'(0));
    check({tag, "_wr_ready"},   32'(bus.wr_ready),   32'(1));
    check({tag, "_state"},      32'(dbg_state),      32'(GUARD));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    set_wr(1'b0, '0, '0);
    bus.blank_mask = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Free-running frames with no writes.
    repeat (FRAME + 1) step();

    // Load A,3,F,0; the current frame keeps zeros, the next shows them.
    exp_q = '{4'hA, 4'h3, 4'hF, 4'h0};
    for (int i = 0; i < N; i++) begin
      set_wr(1'b1, DW'(i), exp_q[i]);
      step();
    end
    set_wr(1'b0, '0, '0);
    run_to(0);
    repeat (2 * FRAME) step();

    // Write held across COMMIT: last cycle before is committed, COMMIT cycle
    // is refused, the one after lands for the following frame.
    run_to(FRAME - 2);
    set_wr(1'b1, 3'd2, 4'h7); step();
    set_wr(1'b1, 3'd2, 4'h8); step();
    set_wr(1'b1, 3'd2, 4'h9); step();
    set_wr(1'b0, '0, '0);
    repeat (2 * FRAME) step();

    // Slot 2 masked for one frame.
    run_to(0);
    bus.blank_mask = 4'b0100;
    repeat (FRAME) step();
    bus.blank_mask = '0;
    repeat (FRAME) step();

    // Two writes to digit 1, then an out-of-range index.
    set_wr(1'b1, 3'd1, 4'h5); step();
    set_wr(1'b1, 3'd1, 4'h9); step();
    set_wr(1'b1, 3'd5, 4'hC); step();
    set_wr(1'b0, '0, '0);
    repeat (2 * FRAME) step();

    // Reset while digit 2 is lit.
    run_to(2 * SLOT + BCYC);
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME + 5) step();

    // Randomized writes and occasional mask changes.
    repeat (600) begin
      set_wr(1'($urandom_range(0, 1)), DW'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 15) == 0) bus.blank_mask = N'($urandom_range(0, 15));
      step();
    end
    set_wr(1'b0, '0, '0);
    bus.blank_mask = '0;
    repeat (FRAME) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
